// File: rtl/sdram_req_queue.sv
// sdram_req_queue: command FIFO in front of the SDRAM controller.
// Drains the FIFO one command at a time over the controller's level req / pulse ack
// handshake, returns read data as a single-cycle pulse, and retires any command
// whose ack never arrives once the watchdog expires.
module sdram_req_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                    iclk,
  input  logic                    ireset_n,
  input  logic                    icmd_valid,
  input  logic                    icmd_we,
  input  logic [ADDR_W-1:0]       icmd_addr,
  input  logic [DATA_W-1:0]       icmd_wdata,
  output logic                    ocmd_ready,
  output logic                    ordata_valid,
  output logic [DATA_W-1:0]       ordata,
  output logic                    owrite_req,
  output logic [ADDR_W-1:0]       owrite_address,
  output logic [DATA_W-1:0]       owrite_data,
  input  logic                    iwrite_ack,
  output logic                    oread_req,
  output logic [ADDR_W-1:0]       oread_address,
  input  logic                    iread_ack,
  input  logic [DATA_W-1:0]       iread_data,
  output logic [$clog2(DEPTH):0]  ocount,
  output logic                    ofull,
  output logic                    oempty,
  output logic                    oerr
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENT_W   = 1 + ADDR_W + DATA_W;
  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          WD_EN   = (TIMEOUT != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [ENT_W-1:0]  mem [DEPTH];

  logic [1:0]        state_q,   state_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic              full_q,    full_d;
  logic              empty_q,   empty_d;
  logic              ready_q,   ready_d;
  logic [WD_W-1:0]   wd_q,      wd_d;
  logic              wr_req_q,  wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_req_q,  rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              rvalid_q,  rvalid_d;
  logic              err_q,     err_d;

  logic              push_c;
  logic              pop_c;
  logic              timeout_c;
  logic [ENT_W-1:0]  head_c;
  logic              head_we_c;
  logic [ADDR_W-1:0] head_addr_c;
  logic [DATA_W-1:0] head_data_c;

  // Head-of-queue decode; a full queue never accepts, even in a popping cycle.
  assign push_c      = icmd_valid && !full_q;
  assign head_c      = mem[rd_ptr_q];
  assign head_we_c   = head_c[ENT_W-1];
  assign head_addr_c = head_c[DATA_W +: ADDR_W];
  assign head_data_c = head_c[DATA_W-1:0];
  assign timeout_c   = WD_EN && (wd_q == WD_W'(TO_LAST));

  // Next-state: issue FSM, watchdog, FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    pop_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          wd_d = '0;
          if (head_we_c) begin
            wr_req_d  = 1'b1;
            wr_addr_d = head_addr_c;
            wr_data_d = head_data_c;
            state_d   = S_WR;
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = head_addr_c;
            state_d   = S_RD;
          end
        end
      end
      S_WR: begin
        if (iwrite_ack) begin
          wr_req_d = 1'b0;
          pop_c    = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout_c) begin
          wr_req_d = 1'b0;
          pop_c    = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else if (WD_EN) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RD: begin
        if (iread_ack) begin
          rd_req_d = 1'b0;
          rdata_d  = iread_data;
          rvalid_d = 1'b1;
          pop_c    = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout_c) begin
          rd_req_d = 1'b0;
          pop_c    = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else if (WD_EN) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    ready_d  = !full_d;
  end

  // State and output registers; reset drops any req immediately.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ready_q   <= 1'b1;
      wd_q      <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ready_q   <= ready_d;
      wd_q      <= wd_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge iclk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {icmd_we, icmd_addr, icmd_wdata};
    end
  end

  assign ocmd_ready     = ready_q;
  assign ordata_valid   = rvalid_q;
  assign ordata         = rdata_q;
  assign owrite_req     = wr_req_q;
  assign owrite_address = wr_addr_q;
  assign owrite_data    = wr_data_q;
  assign oread_req      = rd_req_q;
  assign oread_address  = rd_addr_q;
  assign ocount         = count_q;
  assign ofull          = full_q;
  assign oempty         = empty_q;
  assign oerr           = err_q;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Testbench for sdram_req_queue: controller model with ack credits, scoreboard
// monitor for issued commands and returned read data, directed scenarios.
`timescale 1ns/1ps
module tb_sdram_req_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              icmd_valid, icmd_we;
  logic [ADDR_W-1:0] icmd_addr;
  logic [DATA_W-1:0] icmd_wdata;
  logic              ocmd_ready, ordata_valid;
  logic [DATA_W-1:0] ordata;
  logic              owrite_req, oread_req;
  logic [ADDR_W-1:0] owrite_address, oread_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack, iread_ack;
  logic [DATA_W-1:0] iread_data;
  logic [CNT_W-1:0]  ocount;
  logic              ofull, oempty, oerr;

  cmd_t              exp_issue_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  logic [DATA_W-1:0] mem_m [int];
  int checks   = 0;
  int failures = 0;
  int credits  = 0;
  int ack_delay = 1;
  int rv_cnt   = 0;

  sdram_req_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .iclk(clk), .ireset_n(rst_n),
    .icmd_valid(icmd_valid), .icmd_we(icmd_we), .icmd_addr(icmd_addr), .icmd_wdata(icmd_wdata),
    .ocmd_ready(ocmd_ready), .ordata_valid(ordata_valid), .ordata(ordata),
    .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
    .iwrite_ack(iwrite_ack),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_ack(iread_ack), .iread_data(iread_data),
    .ocount(ocount), .ofull(ofull), .oempty(oempty), .oerr(oerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Controller model: acks a held req after ack_delay cycles while credits remain.
  initial begin : ctrl
    int held;
    held = 0;
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
    iread_data = '0;
    forever begin
      @(posedge clk);
      #1;
      iwrite_ack = 1'b0;
      iread_ack  = 1'b0;
      if (owrite_req || oread_req) held++;
      else held = 0;
      if ((owrite_req || oread_req) && rst_n && credits > 0 && held >= ack_delay) begin
        credits--;
        if (owrite_req) begin
          iwrite_ack = 1'b1;
          mem_m[int'(owrite_address)] = owrite_data;
        end else begin
          iread_ack  = 1'b1;
          iread_data = mem_m.exists(int'(oread_address)) ? mem_m[int'(oread_address)] : 16'hDEAD;
        end
      end
    end
  end

  // Monitor: compares issued commands, req stability, and read pulses with the scoreboard.
  initial begin : mon
    logic pw, pr;
    cmd_t ew, er;
    pw = 1'b0;
    pr = 1'b0;
    ew = '{0, '0, '0};
    er = '{0, '0, '0};
    forever begin
      @(negedge clk);
      if (owrite_req || oread_req)
        check("req_overlap", 32'(owrite_req && oread_req), 32'd0);
      if (owrite_req && !pw) begin
        if (exp_issue_q.size() == 0) fail_now("unexpected_write_issue");
        else begin
          ew = exp_issue_q.pop_front();
          check("issue_is_write", 32'(1'b1), 32'(ew.we));
          check("issue_waddr", 32'(owrite_address), 32'(ew.addr));
          check("issue_wdata", 32'(owrite_data), 32'(ew.data));
        end
      end else if (owrite_req && pw) begin
        check("hold_waddr", 32'(owrite_address), 32'(ew.addr));
        check("hold_wdata", 32'(owrite_data), 32'(ew.data));
      end
      if (oread_req && !pr) begin
        if (exp_issue_q.size() == 0) fail_now("unexpected_read_issue");
        else begin
          er = exp_issue_q.pop_front();
          check("issue_is_read", 32'(1'b0), 32'(er.we));
          check("issue_raddr", 32'(oread_address), 32'(er.addr));
        end
      end else if (oread_req && pr) begin
        check("hold_raddr", 32'(oread_address), 32'(er.addr));
      end
      if (ordata_valid) begin
        rv_cnt++;
        if (exp_rd_q.size() == 0) fail_now("unexpected_rdata_pulse");
        else check("rdata", 32'(ordata), 32'(exp_rd_q.pop_front()));
      end
      pw = owrite_req;
      pr = oread_req;
    end
  end

  task automatic push(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input bit exp_iss, input bit exp_rd, input logic [DATA_W-1:0] rd);
    int n;
    cmd_t c;
    n = 0;
    icmd_valid = 1'b1;
    icmd_we    = we;
    icmd_addr  = a;
    icmd_wdata = d;
    while (!ocmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ocmd_ready) begin
      fail_now("push_ready_timeout");
      icmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      c.we = we;
      c.addr = a;
      c.data = d;
      if (exp_iss) exp_issue_q.push_back(c);
      if (exp_rd) exp_rd_q.push_back(rd);
      @(negedge clk);
      icmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(ocount == '0 && !owrite_req && !oread_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(ocount), 32'd0);
  endtask

  initial begin : guard
    #100000;
    $display("FAIL global_time_limit at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin : main
    int n, cnt;
    cmd_t c;
    icmd_valid = 1'b0;
    icmd_we    = 1'b0;
    icmd_addr  = '0;
    icmd_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",  32'(ocmd_ready), 32'd1);
    check("rst_empty",  32'(oempty), 32'd1);
    check("rst_full",   32'(ofull), 32'd0);
    check("rst_count",  32'(ocount), 32'd0);
    check("rst_wreq",   32'(owrite_req), 32'd0);
    check("rst_rreq",   32'(oread_req), 32'd0);
    check("rst_rvalid", 32'(ordata_valid), 32'd0);
    check("rst_ordata", 32'(ordata), 32'd0);
    check("rst_waddr",  32'(owrite_address), 32'd0);
    check("rst_err",    32'(oerr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write, latency and hold until ack
    credits = 0;
    ack_delay = 1;
    push(1'b1, 22'h000010, 16'hBEEF, 1'b1, 1'b0, '0);
    check("t1_req_after_push_edge", 32'(owrite_req), 32'd0);
    check("t1_count1", 32'(ocount), 32'd1);
    @(negedge clk);
    check("t1_req_next_edge", 32'(owrite_req), 32'd1);
    check("t1_wdata", 32'(owrite_data), 32'hBEEF);
    repeat (3) @(negedge clk);
    check("t1_req_held", 32'(owrite_req), 32'd1);
    credits = 1;
    @(negedge clk);
    @(negedge clk);
    check("t1_req_dropped", 32'(owrite_req), 32'd0);
    check("t1_count0", 32'(ocount), 32'd0);

    // 2: write then read back
    credits = 1000;
    push(1'b1, 22'h20, 16'h1234, 1'b1, 1'b0, '0);
    push(1'b0, 22'h20, 16'h0000, 1'b1, 1'b1, 16'h1234);
    drain("t2_drain");
    check("t2_ordata_holds", 32'(ordata), 32'h1234);

    // 3: fill to full with acks withheld, refuse 9th, pop, push+pop
    credits = 0;
    for (int i = 0; i < 8; i++)
      push(1'b1, 22'(32'h200 + i), 16'(32'h3000 + i), 1'b1, 1'b0, '0);
    check("t3_full", 32'(ofull), 32'd1);
    check("t3_ready", 32'(ocmd_ready), 32'd0);
    check("t3_count8", 32'(ocount), 32'd8);
    icmd_valid = 1'b1;
    icmd_we = 1'b1;
    icmd_addr = 22'h2FF;
    icmd_wdata = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    icmd_valid = 1'b0;
    check("t3_ninth_refused", 32'(ocount), 32'd8);
    credits = 1;
    @(negedge clk);
    @(negedge clk);
    check("t3_one_ack_count7", 32'(ocount), 32'd7);
    credits = 1;
    @(negedge clk);
    icmd_valid = 1'b1;
    icmd_we = 1'b1;
    icmd_addr = 22'h208;
    icmd_wdata = 16'h3008;
    @(posedge clk);
    c.we = 1'b1;
    c.addr = 22'h208;
    c.data = 16'h3008;
    exp_issue_q.push_back(c);
    @(negedge clk);
    icmd_valid = 1'b0;
    check("t3_pushpop_count7", 32'(ocount), 32'd7);
    check("t3_not_full", 32'(ofull), 32'd0);
    credits = 1000;
    drain("t3_drain");

    // 4: ten commands across pointer wrap
    for (int i = 0; i < 5; i++)
      push(1'b1, 22'(32'h100 + i), 16'(32'hA000 + i), 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++)
      push(1'b0, 22'(32'h100 + i), 16'h0000, 1'b1, 1'b1, 16'(32'hA000 + i));
    drain("t4_drain");
    check("t4_ordata_last", 32'(ordata), 32'hA004);

    // 5: watchdog aborts unacked read; following write still completes
    credits = 0;
    push(1'b0, 22'h30, 16'h0000, 1'b1, 1'b0, '0);
    push(1'b1, 22'h31, 16'h7777, 1'b1, 1'b0, '0);
    n = 0;
    while (!oread_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (oread_req && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_req_hold_cycles", 32'(cnt), 32'd20);
    check("t5_err", 32'(oerr), 32'd1);
    check("t5_ordata_unchanged", 32'(ordata), 32'hA004);
    credits = 1000;
    drain("t5_drain");
    check("t5_err_sticky", 32'(oerr), 32'd1);
    check("t5_write_landed", 32'(mem_m.exists(32'h31) ? mem_m[32'h31] : 16'h0), 32'h7777);

    // 6: reset while a read is in flight with 3 entries queued
    credits = 0;
    push(1'b0, 22'h50, 16'h0000, 1'b1, 1'b0, '0);
    push(1'b0, 22'h51, 16'h0000, 1'b0, 1'b0, '0);
    push(1'b0, 22'h52, 16'h0000, 1'b0, 1'b0, '0);
    check("t6_rreq_before", 32'(oread_req), 32'd1);
    check("t6_count3", 32'(ocount), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rreq_async_drop", 32'(oread_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    credits = 1000;
    @(negedge clk);
    check("t6_count0", 32'(ocount), 32'd0);
    check("t6_empty", 32'(oempty), 32'd1);
    check("t6_err_clear", 32'(oerr), 32'd0);
    check("t6_ready", 32'(ocmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("t6_no_reissue", 32'(oread_req), 32'd0);
    push(1'b1, 22'h60, 16'h6060, 1'b1, 1'b0, '0);
    drain("t6_post_reset_drain");

    // End-of-run scoreboard state
    repeat (3) @(negedge clk);
    check("end_issue_queue_empty", 32'(exp_issue_q.size()), 32'd0);
    check("end_rdata_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    check("end_rdata_pulses", 32'(rv_cnt), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
